key_pio_sequencer: RTL and testbench

- Hardware Avalon-MM master that services the 4-bit key PIO (edge-capture/irq-mask type) without CPU involvement.
- After reset it programs the PIO irq mask.
- On PIO irq it reads the edge-capture register, clears it, and pushes the captured key bits as an event into a small FIFO.
- Sits between the key PIO slave port and a downstream event consumer (Nios-side status logic or LED/UI FSM).

---
 rtl/key_seq_pkg.sv | 17 +
 rtl/key_evt_fifo.sv | 48 ++++
 rtl/key_pio_sequencer.sv | 172 +++++++++++++++++
 tb/tb_key_pio_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_seq_pkg.sv
// Shared FSM state encoding and PIO register map for the key PIO sequencer.
package key_seq_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    MASK_WR,
    RD_CAP,
    CLR,
    PUSH
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO; head reads as zero while empty.
module key_evt_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/key_pio_sequencer.sv
// Avalon-MM master that programs the key PIO irq mask and turns PIO edge captures into FIFO events.
// Define KEY_SEQ_TIMESTAMP_EN to add a free-running cycle timestamp to each event (evt_time port).
module key_pio_sequencer
  import key_seq_pkg::*;
#(
  parameter int               KEY_W      = 4,
  parameter int               FIFO_DEPTH = 8,
  parameter logic [KEY_W-1:0] INIT_MASK  = {KEY_W{1'b1}},
  parameter int               TS_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             pio_irq,
  input  logic [KEY_W-1:0] cfg_mask,
  input  logic             cfg_mask_load,
  output logic [KEY_W-1:0] cur_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KEY_W-1:0] evt_keys,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
`ifdef KEY_SEQ_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  evt_time
`endif
);

`ifdef KEY_SEQ_TIMESTAMP_EN
  localparam int FW = KEY_W + TS_W;
`else
  localparam int FW = KEY_W;
  localparam int unused_ts_w = TS_W;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [KEY_W-1:0] r_mask_pend;
  logic [KEY_W-1:0] r_cap;
  logic [KEY_W-1:0] r_cur_mask;
  logic             r_overflow;
  logic             w_cs;
  logic             w_wn;
  logic [1:0]       w_addr;
  logic [31:0]      w_wdata;
  logic             w_busy;
  logic             w_push_req;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_set;
  logic [FW-1:0]    w_fifo_din;
  logic [FW-1:0]    w_fifo_head;
  logic             w_unused_rd;

  assign w_unused_rd = ^m_readdata[31:KEY_W];

  always_comb begin
    w_next     = r_state;
    w_cs       = 1'b0;
    w_wn       = 1'b1;
    w_addr     = ADDR_EDGE;
    w_wdata    = '0;
    w_busy     = 1'b1;
    w_push_req = 1'b0;
    case (r_state)
      INIT: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = ADDR_MASK;
        w_wdata = 32'(INIT_MASK);
        w_next  = IDLE;
      end
      IDLE: begin
        w_busy = 1'b0;
        if (cfg_mask_load) w_next = MASK_WR;
        else if (pio_irq)  w_next = RD_CAP;
      end
      MASK_WR: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = ADDR_MASK;
        w_wdata = 32'(r_mask_pend);
        w_next  = IDLE;
      end
      RD_CAP: w_next = CLR;
      CLR: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_next = PUSH;
      end
      PUSH: begin
        w_push_req = |r_cap;
        w_next     = IDLE;
      end
      default: w_next = INIT;
    endcase
  end

  // Bus outputs are forced to idle values while reset is asserted, even though the state is INIT.
  assign m_chipselect = w_cs & reset_n;
  assign m_write_n    = w_wn | ~reset_n;
  assign m_address    = reset_n ? w_addr : ADDR_DATA;
  assign m_writedata  = reset_n ? w_wdata : '0;
  assign busy         = w_busy;
  assign cur_mask     = r_cur_mask;
  assign overflow     = r_overflow;
  assign evt_valid    = !w_empty;
  assign w_pop        = evt_valid && evt_ready;
  assign w_ovf_set    = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= INIT;
      r_cur_mask <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == INIT)    r_cur_mask <= INIT_MASK;
      if (r_state == MASK_WR) r_cur_mask <= r_mask_pend;
      if (w_ovf_set)          r_overflow <= 1'b1;
      else if (overflow_clr)  r_overflow <= 1'b0;
    end
  end

  // Read data is registered by the PIO, so in RD_CAP it reflects the EDGE address driven in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && cfg_mask_load) r_mask_pend <= cfg_mask;
    if (r_state == RD_CAP)                r_cap       <= m_readdata[KEY_W-1:0];
  end

`ifdef KEY_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_ts_cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ts <= '0;
    else          r_ts <= r_ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (r_state == RD_CAP) r_ts_cap <= r_ts;
  end

  assign w_fifo_din = {r_ts_cap, r_cap};
  assign evt_time   = w_fifo_head[FW-1:KEY_W];
`else
  assign w_fifo_din = r_cap;
`endif

  assign evt_keys = w_fifo_head[KEY_W-1:0];

  key_evt_fifo #(
    .DATA_W (FW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push_req),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_key_pio_sequencer.sv
// Directed bench for key_pio_sequencer with a small behavioural model of the key PIO slave.
module tb_key_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        pio_irq;
  logic [3:0]  cfg_mask;
  logic        cfg_mask_load;
  logic [3:0]  cur_mask;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_keys;
  logic        overflow;
  logic        overflow_clr;
  logic        busy;
`ifdef KEY_SEQ_TIMESTAMP_EN
  logic [15:0] evt_time;
`endif

  logic [3:0]  pio_mask = 4'h0;
  logic [3:0]  pio_edge = 4'h0;
  logic [3:0]  key_evt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  key_pio_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .pio_irq       (pio_irq),
    .cfg_mask      (cfg_mask),
    .cfg_mask_load (cfg_mask_load),
    .cur_mask      (cur_mask),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_keys      (evt_keys),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .busy          (busy)
`ifdef KEY_SEQ_TIMESTAMP_EN
    ,
    .evt_time      (evt_time)
`endif
  );

  // Key PIO model: registered readdata, edge capture cleared by a write to EDGE.
  always @(posedge clk) begin
    m_readdata <= (m_address == 2'd3) ? {28'h0, pio_edge} :
                  (m_address == 2'd2) ? {28'h0, pio_mask} : 32'h0;
    if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
    if (!reset_n) pio_edge <= 4'h0;
    else if (m_chipselect && !m_write_n && m_address == 2'd3) pio_edge <= 4'h0;
    else pio_edge <= pio_edge | key_evt;
  end

  assign pio_irq = |(pio_edge & pio_mask);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", m_chipselect); end
    checks++; if (m_write_n !== 1'b1) begin errors++; $display("FAIL rst_write_n got %b exp 1", m_write_n); end
    checks++; if (m_address !== 2'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", m_address); end
    checks++; if (m_writedata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", m_writedata); end
    checks++; if (cur_mask !== 4'h0) begin errors++; $display("FAIL rst_cur_mask got %h exp 0", cur_mask); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got %b exp 0", evt_valid); end
    checks++; if (evt_keys !== 4'h0) begin errors++; $display("FAIL rst_evt_keys got %h exp 0", evt_keys); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
    reset_n = 1'b1;
    #1;
    checks++; if (m_chipselect !== 1'b1) begin errors++; $display("FAIL init_cs got %b exp 1", m_chipselect); end
    checks++; if (m_write_n !== 1'b0) begin errors++; $display("FAIL init_write_n got %b exp 0", m_write_n); end
    checks++; if (m_address !== 2'd2) begin errors++; $display("FAIL init_addr got %0d exp 2", m_address); end
    checks++; if (m_writedata !== 32'hF) begin errors++; $display("FAIL init_wdata got %h exp f", m_writedata); end
    tick();
    checks++; if (cur_mask !== 4'hF) begin errors++; $display("FAIL init_cur_mask got %h exp f", cur_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_idle_busy got %b exp 0", busy); end
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs got %b exp 0", m_chipselect); end
    checks++; if (m_address !== 2'd3) begin errors++; $display("FAIL idle_addr got %0d exp 3", m_address); end
    checks++; if (pio_mask !== 4'hF) begin errors++; $display("FAIL pio_mask got %h exp f", pio_mask); end
  endtask

  task automatic test_irq_service();
    key_evt = 4'b0100;
    tick();
    key_evt = 4'h0;
    checks++; if (pio_irq !== 1'b1) begin errors++; $display("FAIL irq_raised got %b exp 1", pio_irq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL irq_t_busy got %b exp 0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rdcap_busy got %b exp 1", busy); end
    checks++; if (m_address !== 2'd3 || m_chipselect !== 1'b0) begin errors++; $display("FAIL rdcap_bus got addr %0d cs %b exp addr 3 cs 0", m_address, m_chipselect); end
    cfg_mask      = 4'h5;
    cfg_mask_load = 1'b1;
    tick();
    cfg_mask_load = 1'b0;
    checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 2'd3 || m_writedata !== 32'h0) begin
      errors++; $display("FAIL clr_bus got cs %b wn %b addr %0d wdata %h exp 1 0 3 0", m_chipselect, m_write_n, m_address, m_writedata);
    end
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL push_early_valid got %b exp 0", evt_valid); end
    checks++; if (pio_irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b exp 0", pio_irq); end
    tick();
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL evt_valid_t4 got %b exp 1", evt_valid); end
    checks++; if (evt_keys !== 4'b0100) begin errors++; $display("FAIL evt_keys_t4 got %b exp 0100", evt_keys); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL back_idle_busy got %b exp 0", busy); end
    checks++; if (cur_mask !== 4'hF) begin errors++; $display("FAIL busy_load_ignored got %h exp f", cur_mask); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL pop_empty got %b exp 0", evt_valid); end
  endtask

  task automatic test_mask_priority();
    key_evt = 4'b0001;
    tick();
    key_evt       = 4'h0;
    cfg_mask      = 4'b0011;
    cfg_mask_load = 1'b1;
    tick();
    cfg_mask_load = 1'b0;
    checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 2'd2 || m_writedata !== 32'h3) begin
      errors++; $display("FAIL maskwr_bus got cs %b wn %b addr %0d wdata %h exp 1 0 2 3", m_chipselect, m_write_n, m_address, m_writedata);
    end
    tick();
    checks++; if (cur_mask !== 4'h3) begin errors++; $display("FAIL maskwr_cur got %h exp 3", cur_mask); end
    checks++; if (busy !== 1'b0 || pio_irq !== 1'b1) begin errors++; $display("FAIL maskwr_idle got busy %b irq %b exp 0 1", busy, pio_irq); end
    tick();
    tick();
    tick();
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_keys !== 4'b0001) begin errors++; $display("FAIL mask_then_irq got v %b keys %b exp 1 0001", evt_valid, evt_keys); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    cfg_mask      = 4'hF;
    cfg_mask_load = 1'b1;
    tick();
    cfg_mask_load = 1'b0;
    tick();
    checks++; if (cur_mask !== 4'hF) begin errors++; $display("FAIL ovf_mask_restore got %h exp f", cur_mask); end
    for (int i = 0; i < 9; i++) begin
      key_evt = 4'(i + 1);
      tick();
      key_evt = 4'h0;
      repeat (5) tick();
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (evt_valid !== 1'b1 || evt_keys !== 4'h1) begin errors++; $display("FAIL ovf_head got v %b keys %h exp 1 1", evt_valid, evt_keys); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_keys !== 4'(i + 1)) begin
        errors++; $display("FAIL drain_%0d got v %b keys %h exp 1 %h", i, evt_valid, evt_keys, 4'(i + 1));
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", evt_valid); end
  endtask

  task automatic test_reset_mid_seq();
    key_evt = 4'b1000;
    tick();
    key_evt = 4'h0;
    repeat (4) tick();
    checks++; if (evt_valid !== 1'b1 || evt_keys !== 4'b1000) begin errors++; $display("FAIL prefill got v %b keys %b exp 1 1000", evt_valid, evt_keys); end
    key_evt = 4'b0010;
    tick();
    key_evt = 4'h0;
    tick();
    tick();
    checks++; if (m_chipselect !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL in_clr got cs %b busy %b exp 1 1", m_chipselect, busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_address !== 2'd0 || m_writedata !== 32'h0) begin
      errors++; $display("FAIL midrst_bus got cs %b wn %b addr %0d wdata %h exp 0 1 0 0", m_chipselect, m_write_n, m_address, m_writedata);
    end
    checks++; if (cur_mask !== 4'h0 || busy !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got mask %h busy %b ovf %b exp 0 1 0", cur_mask, busy, overflow); end
    checks++; if (evt_valid !== 1'b0 || evt_keys !== 4'h0) begin errors++; $display("FAIL midrst_fifo got v %b keys %h exp 0 0", evt_valid, evt_keys); end
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 2'd2 || m_writedata !== 32'hF) begin
      errors++; $display("FAIL reinit_bus got cs %b wn %b addr %0d wdata %h exp 1 0 2 f", m_chipselect, m_write_n, m_address, m_writedata);
    end
    tick();
    checks++; if (cur_mask !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL reinit_idle got mask %h busy %b exp f 0", cur_mask, busy); end
  endtask

`ifdef KEY_SEQ_TIMESTAMP_EN
  task automatic test_timestamp();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (99) tick();
    key_evt = 4'h1;
    tick();
    key_evt = 4'h0;
    repeat (4) tick();
    checks++; if (evt_valid !== 1'b1 || evt_time !== 16'd101) begin errors++; $display("FAIL ts_101 got v %b time %0d exp 1 101", evt_valid, evt_time); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_time !== 16'd0) begin errors++; $display("FAIL ts_empty got %0d exp 0", evt_time); end
    repeat (65534 - 105) tick();
    key_evt = 4'h2;
    tick();
    key_evt = 4'h0;
    repeat (4) tick();
    checks++; if (evt_valid !== 1'b1 || evt_keys !== 4'h2 || evt_time !== 16'd0) begin
      errors++; $display("FAIL ts_wrap got v %b keys %h time %0d exp 1 2 0", evt_valid, evt_keys, evt_time);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask
`endif

  initial begin
    reset_n       = 1'b0;
    cfg_mask      = 4'h0;
    cfg_mask_load = 1'b0;
    evt_ready     = 1'b0;
    overflow_clr  = 1'b0;
    key_evt       = 4'h0;
    test_reset();
    test_irq_service();
    test_mask_priority();
    test_overflow();
    test_reset_mid_seq();
`ifdef KEY_SEQ_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
